// File: rtl/res_ram_arb_if.sv
// res_ram_arb_if: writeback, host-read and RAM-port bundle around the result RAM arbiter.
interface res_ram_arb_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic              wb_req;
    logic [DATA_W-1:0] wb_data;
    logic              wb_gnt;
    logic              wb_full;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              clear;
    logic [ADDR_W:0]   words;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  wb_req, wb_data, rd_req, rd_addr, clear, ram_rdata,
        output wb_gnt, wb_full, rd_gnt, rd_valid, rd_data, words, ram_en, ram_we, ram_addr, ram_wdata
    );
    modport master (
        output wb_req, wb_data, rd_req, rd_addr, clear, ram_rdata,
        input  wb_gnt, wb_full, rd_gnt, rd_valid, rd_data, words, ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/res_ram_arb.sv
// res_ram_arb: shares the single-port result RAM between atomic writeback bursts and host reads,
// tracking fill level and applying clears only between operations.
module res_ram_arb #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32,
    parameter int BURST  = 4
) (
    input logic          clk,
    input logic          rst,
    res_ram_arb_if.slave bus
);
    localparam int BW = BURST > 1 ? $clog2(BURST) : 1;
    localparam logic [ADDR_W:0] FULL_AT = (ADDR_W+1)'((1 << ADDR_W) - BURST);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W:0]   r_words;
    logic [BW-1:0]     r_beat;
    logic              r_clear_pend;
    logic              r_last_rd;
    logic              r_rd_valid;
    logic              w_idle;
    logic              w_write;
    logic              w_read;
    logic              w_full;
    logic              w_clr;
    logic              w_wb_el;
    logic              w_wb_win;
    logic              w_rd_win;
    logic              w_last_beat;

    assign w_idle      = r_state == IDLE;
    assign w_write     = r_state == WRITE;
    assign w_read      = r_state == READ;
    assign w_full      = r_words > FULL_AT;
    // a clear seen in IDLE pre-empts any grant decided in the same cycle
    assign w_clr       = r_clear_pend | bus.clear;
    assign w_wb_el     = bus.wb_req & ~w_full;
    assign w_wb_win    = w_idle & ~w_clr & w_wb_el & (~bus.rd_req | r_last_rd);
    assign w_rd_win    = w_idle & ~w_clr & bus.rd_req & (~w_wb_el | ~r_last_rd);
    assign w_last_beat = r_beat == BW'(BURST - 1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_wb_win ? WRITE : w_rd_win ? READ : IDLE;
            WRITE:   w_next = w_last_beat ? IDLE : WRITE;
            default: w_next = IDLE;
        endcase
    end

    assign bus.wb_gnt    = w_write;
    assign bus.rd_gnt    = w_read;
    assign bus.wb_full   = w_full;
    assign bus.words     = r_words;
    assign bus.ram_en    = ~w_idle;
    assign bus.ram_we    = w_write;
    assign bus.ram_addr  = w_write ? r_wr_ptr : w_read ? r_rd_addr : '0;
    assign bus.ram_wdata = w_write ? bus.wb_data : '0;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_data   = r_rd_valid ? bus.ram_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_wr_ptr     <= '0;
            r_rd_addr    <= '0;
            r_words      <= '0;
            r_beat       <= '0;
            r_clear_pend <= 1'b0;
            r_last_rd    <= 1'b1;
            r_rd_valid   <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_rd_valid   <= w_read;
            r_clear_pend <= (w_idle & w_clr) ? 1'b0 : r_clear_pend | bus.clear;
            if (w_rd_win)
                r_rd_addr <= bus.rd_addr;
            if (w_idle & w_clr) begin
                r_wr_ptr <= '0;
                r_words  <= '0;
            end
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_words  <= r_words + 1'b1;
                r_beat   <= w_last_beat ? '0 : r_beat + 1'b1;
                if (w_last_beat)
                    r_last_rd <= 1'b0;
            end
            if (w_read)
                r_last_rd <= 1'b1;
        end
    end
endmodule

// File: tb/tb_res_ram_arb.sv
// tb_res_ram_arb: scenario and randomized bench for res_ram_arb against a RAM model and a
// transaction-level scoreboard of write pointer, fill level and memory contents.
module tb_res_ram_arb;
    logic        clk = 1'b0;
    logic        rst;
    int          n_vec = 0;
    int          n_err = 0;
    logic [3:0]  m_ptr;
    int          m_words;
    logic [31:0] m_mem [16] = '{default: 32'h0};
    logic [31:0] ram [16] = '{default: 32'h0};
    time         t_wb;
    time         t_rd;
    time         ev_t [$];
    bit          ev_w [$];

    res_ram_arb_if bus ();
    res_ram_arb dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.ram_en && bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
        if (bus.ram_en && !bus.ram_we) bus.ram_rdata <= ram[bus.ram_addr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.wb_req = 1'b0;
        bus.rd_req = 1'b0;
        bus.clear = 1'b0;
        bus.wb_data = '0;
        bus.rd_addr = '0;
        nxt();
        nxt();
        rst = 1'b0;
        m_ptr = '0;
        m_words = 0;
    endtask

    task automatic wb_burst(input logic [31:0] base, output int lat);
        int n;
        int t;
        n = 0;
        t = 0;
        lat = -1;
        bus.wb_req = 1'b1;
        while (n < 4 && t < 24) begin
            bus.wb_data = base + n;
            @(negedge clk);
            if (bus.wb_gnt) begin
                if (n == 0) begin
                    lat = t;
                    t_wb = $time;
                    ev_t.push_back($time);
                    ev_w.push_back(1'b1);
                end
                n_vec++;
                if (bus.ram_addr !== m_ptr || bus.ram_wdata !== base + n || bus.ram_we !== 1'b1 || bus.rd_gnt !== 1'b0) begin
                    n_err++;
                    $display("FAIL wb_beat%0d: addr=%0d data=%h we=%b rd_gnt=%b, want addr=%0d data=%h we=1 rd_gnt=0",
                             n, bus.ram_addr, bus.ram_wdata, bus.ram_we, bus.rd_gnt, m_ptr, base + n);
                end
                m_mem[m_ptr] = base + n;
                m_ptr++;
                m_words++;
                n++;
            end else if (n > 0) begin
                n_vec++;
                n_err++;
                $display("FAIL wb_atomic: wb_gnt dropped after %0d beats, want 4 consecutive", n);
                t = 24;
            end
            t++;
            nxt();
        end
        bus.wb_req = 1'b0;
        n_vec++;
        if (n != 4 || bus.words !== 5'(m_words) || bus.wb_full !== (m_words > 12)) begin
            n_err++;
            $display("FAIL wb_done: beats=%0d words=%0d full=%b, want beats=4 words=%0d full=%b",
                     n, bus.words, bus.wb_full, m_words, m_words > 12);
        end
    endtask

    task automatic host_read(input logic [3:0] a);
        int t;
        bit got;
        logic [31:0] exp;
        t = 0;
        got = 1'b0;
        exp = '0;
        bus.rd_req = 1'b1;
        bus.rd_addr = a;
        while (!got && t < 24) begin
            @(negedge clk);
            if (bus.rd_gnt) begin
                got = 1'b1;
                t_rd = $time;
                ev_t.push_back($time);
                ev_w.push_back(1'b0);
                exp = m_mem[a];
                n_vec++;
                if (bus.ram_addr !== a || bus.ram_we !== 1'b0 || bus.wb_gnt !== 1'b0 || bus.rd_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL rd_issue: addr=%0d we=%b wb_gnt=%b rd_valid=%b, want addr=%0d we=0 wb_gnt=0 rd_valid=0",
                             bus.ram_addr, bus.ram_we, bus.wb_gnt, bus.rd_valid, a);
                end
            end
            t++;
            nxt();
        end
        bus.rd_req = 1'b0;
        @(negedge clk);
        n_vec++;
        if (!got || bus.rd_valid !== 1'b1 || bus.rd_data !== exp) begin
            n_err++;
            $display("FAIL rd_data: granted=%b valid=%b data=%h, want granted=1 valid=1 data=%h (addr %0d)",
                     got, bus.rd_valid, bus.rd_data, exp, a);
        end
        nxt();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.wb_req = 1'b1;
        bus.rd_req = 1'b1;
        bus.clear = 1'b0;
        bus.wb_data = 32'hFFFF_FFFF;
        bus.rd_addr = 4'd5;
        nxt();
        @(negedge clk);
        n_vec++;
        if ({bus.wb_gnt, bus.rd_gnt, bus.rd_valid, bus.ram_en, bus.ram_we, bus.wb_full} !== 6'b0) begin
            n_err++;
            $display("FAIL rst_ctrl: gnt/rgnt/valid/en/we/full=%b, want 000000",
                     {bus.wb_gnt, bus.rd_gnt, bus.rd_valid, bus.ram_en, bus.ram_we, bus.wb_full});
        end
        n_vec++;
        if (bus.ram_addr !== 4'd0 || bus.ram_wdata !== 32'd0 || bus.rd_data !== 32'd0 || bus.words !== 5'd0) begin
            n_err++;
            $display("FAIL rst_data: addr=%0d wdata=%h rdata=%h words=%0d, want all 0",
                     bus.ram_addr, bus.ram_wdata, bus.rd_data, bus.words);
        end
        do_reset();
    endtask

    task automatic test_single_burst();
        int lat;
        wb_burst(32'hA0, lat);
        n_vec++;
        if (lat != 1) begin
            n_err++;
            $display("FAIL single_lat: first grant after %0d cycles, want 1", lat);
        end
    endtask

    task automatic test_tie();
        int lat;
        do_reset();
        fork
            wb_burst(32'hA0, lat);
            host_read(4'd2);
        join
        n_vec++;
        if (lat != 1 || t_rd - t_wb != 64'd50) begin
            n_err++;
            $display("FAIL tie_order: wb lat=%0d rd-wb=%0t, want lat=1 rd-wb=50", lat, t_rd - t_wb);
        end
    endtask

    task automatic test_full_clear();
        int lat;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wb_burst(32'h100 * (i + 1), lat);
            n_vec++;
            if (lat != 1) begin
                n_err++;
                $display("FAIL b2b_lat%0d: grant after %0d cycles, want 1", i, lat);
            end
        end
        bus.wb_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_vec++;
            if (bus.wb_gnt !== 1'b0 || bus.wb_full !== 1'b1) begin
                n_err++;
                $display("FAIL full_block: wb_gnt=%b wb_full=%b, want 0 1", bus.wb_gnt, bus.wb_full);
            end
            nxt();
        end
        bus.clear = 1'b1;
        nxt();
        bus.clear = 1'b0;
        m_ptr = '0;
        m_words = 0;
        n_vec++;
        if (bus.words !== 5'd0 || bus.wb_full !== 1'b0) begin
            n_err++;
            $display("FAIL clear_words: words=%0d full=%b, want 0 0", bus.words, bus.wb_full);
        end
        wb_burst(32'h500, lat);
        n_vec++;
        if (lat != 1) begin
            n_err++;
            $display("FAIL clear_regrant: grant after %0d cycles, want 1", lat);
        end
    endtask

    task automatic test_rr();
        do_reset();
        ev_t.delete();
        ev_w.delete();
        fork
            begin
                int lw;
                repeat (3) wb_burst($urandom, lw);
            end
            repeat (3) host_read(4'($urandom_range(0, 15)));
        join
        n_vec++;
        if (ev_w.size() != 6) begin
            n_err++;
            $display("FAIL rr_count: %0d grants, want 6", ev_w.size());
        end
        for (int i = 0; i < ev_w.size(); i++) begin
            n_vec++;
            if (ev_w[i] !== (i % 2 == 0) || (i > 0 && ev_t[i] - ev_t[i-1] != (ev_w[i-1] ? 64'd50 : 64'd20))) begin
                n_err++;
                $display("FAIL rr_order%0d: wb=%b gap=%0t, want wb=%b gap=%0d", i, ev_w[i],
                         i > 0 ? ev_t[i] - ev_t[i-1] : 64'd0, i % 2 == 0, i == 0 ? 0 : (ev_w[i-1] ? 50 : 20));
            end
        end
    endtask

    task automatic test_clear_mid();
        int lat;
        do_reset();
        fork
            wb_burst(32'hC0, lat);
            begin
                nxt();
                nxt();
                bus.clear = 1'b1;
                nxt();
                bus.clear = 1'b0;
            end
        join
        m_ptr = '0;
        m_words = 0;
        wb_burst(32'hD0, lat);
        n_vec++;
        if (lat != 2) begin
            n_err++;
            $display("FAIL clear_mid_lat: grant after %0d cycles, want 2", lat);
        end
    endtask

    task automatic test_random();
        do_reset();
        fork
            begin
                int lw;
                repeat (14) begin
                    if (m_words > 12 || $urandom_range(0, 3) == 0) begin
                        bus.clear = 1'b1;
                        nxt();
                        bus.clear = 1'b0;
                        m_ptr = '0;
                        m_words = 0;
                    end
                    repeat ($urandom_range(0, 2)) nxt();
                    wb_burst($urandom, lw);
                end
            end
            repeat (16) begin
                repeat ($urandom_range(0, 3)) nxt();
                host_read(4'($urandom_range(0, 15)));
            end
        join
    endtask

    task automatic test_rst_mid();
        int n;
        int lat;
        do_reset();
        n = 0;
        bus.wb_req = 1'b1;
        for (int t = 0; t < 10 && n < 2; t++) begin
            bus.wb_data = 32'hF0 + n;
            @(negedge clk);
            if (bus.wb_gnt) n++;
            nxt();
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if (n != 2 || {bus.wb_gnt, bus.rd_gnt, bus.rd_valid, bus.ram_en, bus.ram_we, bus.wb_full} !== 6'b0 ||
            bus.ram_addr !== 4'd0 || bus.ram_wdata !== 32'd0 || bus.words !== 5'd0) begin
            n_err++;
            $display("FAIL rst_mid: beats=%0d ctrl=%b addr=%0d wdata=%h words=%0d, want beats=2 ctrl=000000 addr=0 wdata=0 words=0",
                     n, {bus.wb_gnt, bus.rd_gnt, bus.rd_valid, bus.ram_en, bus.ram_we, bus.wb_full},
                     bus.ram_addr, bus.ram_wdata, bus.words);
        end
        bus.wb_req = 1'b0;
        m_mem[0] = 32'hF0;
        m_mem[1] = 32'hF1;
        nxt();
        rst = 1'b0;
        m_ptr = '0;
        m_words = 0;
        host_read(4'd2);
        wb_burst(32'hE0, lat);
        host_read(4'd1);
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_tie();
        test_full_clear();
        test_rr();
        test_clear_mid();
        test_random();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
